// File: rtl/reset_pkg.sv
// Shared types and constants for the chip-level reset sequencer.
package reset_pkg;

  typedef enum logic [1:0] {
    StPor,
    StHold,
    StPeriph,
    StRun
  } rst_state_t;

  typedef logic [1:0] rst_cause_t;

  localparam rst_cause_t CAUSE_POR = 2'b01;
  localparam rst_cause_t CAUSE_WDT = 2'b10;
  localparam rst_cause_t CAUSE_EXT = 2'b11;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level input.
module sync_bit #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= {STAGES{RESET_VAL}};
    end else begin
      chain_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Chip reset controller: merges power-good, watchdog and external resets into staged
// peripheral/CPU resets and records the most recent cause.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int unsigned POR_CYCLES  = 4,
  parameter int unsigned STRETCH     = 16,
  parameter int unsigned PERIPH_GAP  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ext_reset_n,
  input  logic       wdt_reset,
  output logic       power_on_reset,
  output logic       periph_reset,
  output logic       cpu_reset,
  output logic [1:0] cause,
  output logic       busy
);

  localparam int unsigned CntMax = max3(POR_CYCLES, STRETCH, PERIPH_GAP);
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] PorLoad     = CntW'(POR_CYCLES - 1);
  localparam logic [CntW-1:0] StretchLoad = CntW'(STRETCH - 1);
  localparam logic [CntW-1:0] GapLoad     = CntW'(PERIPH_GAP - 1);

  rst_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  rst_cause_t      cause_q, cause_d;
  logic            por_arm_q;
  logic            ext_sync;
  logic            req;
  logic            cnt_zero;
  rst_cause_t      req_cause;

  sync_bit #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_ext_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ext_reset_n),
    .q     (ext_sync)
  );

  assign req       = wdt_reset | ~ext_sync;
  assign req_cause = ~ext_sync ? CAUSE_EXT : CAUSE_WDT;
  assign cnt_zero  = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      StPor: begin
        // The first edge out of reset only arms the count, so POR spans POR_CYCLES edges.
        if (por_arm_q) begin
          if (cnt_zero) begin
            state_d = StHold;
            cnt_d   = StretchLoad;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      StHold: begin
        if (req) begin
          cnt_d   = StretchLoad;
          cause_d = req_cause;
        end else if (cnt_zero) begin
          state_d = StPeriph;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPeriph: begin
        if (req) begin
          state_d = StHold;
          cnt_d   = StretchLoad;
          cause_d = req_cause;
        end else if (cnt_zero) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRun: begin
        if (req) begin
          state_d = StHold;
          cnt_d   = StretchLoad;
          cause_d = req_cause;
        end
      end
      default: begin
        state_d = StPor;
        cnt_d   = PorLoad;
      end
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StPor;
      cnt_q          <= PorLoad;
      cause_q        <= CAUSE_POR;
      por_arm_q      <= 1'b0;
      power_on_reset <= 1'b1;
      periph_reset   <= 1'b1;
      cpu_reset      <= 1'b1;
      busy           <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cause_q        <= cause_d;
      por_arm_q      <= 1'b1;
      power_on_reset <= (state_d == StPor);
      periph_reset   <= (state_d == StPor) || (state_d == StHold);
      cpu_reset      <= (state_d != StRun);
      busy           <= (state_d != StRun);
    end
  end

  assign cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomised bench for reset_sequencer against a timeline-based reference model.
module tb_reset_sequencer;

  localparam int POR_CYCLES  = 4;
  localparam int STRETCH     = 16;
  localparam int PERIPH_GAP  = 4;
  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       ext_reset_n;
  logic       wdt_reset;
  logic       power_on_reset;
  logic       periph_reset;
  logic       cpu_reset;
  logic [1:0] cause;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;

  // Model: por falls after edge por_end; a request accepted at edge b releases
  // periph after b+STRETCH and cpu after b+STRETCH+PERIPH_GAP.
  int         por_end = 0;
  int         base    = 0;
  logic [1:0] m_cause = 2'b01;
  bit         ext_hist[$];

  reset_sequencer #(
    .POR_CYCLES  (POR_CYCLES),
    .STRETCH     (STRETCH),
    .PERIPH_GAP  (PERIPH_GAP),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ext_reset_n    (ext_reset_n),
    .wdt_reset      (wdt_reset),
    .power_on_reset (power_on_reset),
    .periph_reset   (periph_reset),
    .cpu_reset      (cpu_reset),
    .cause          (cause),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b after edge %0d", tag, obs, exp, k);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic e);
    bit   s;
    logic e_por, e_per, e_cpu;
    reset       = r;
    wdt_reset   = w;
    ext_reset_n = e;
    @(posedge clk);
    #1;
    if (r) begin
      por_end = k + 1 + POR_CYCLES;
      base    = por_end;
      m_cause = 2'b01;
      ext_hist.delete();
      for (int i = 0; i < SYNC_STAGES; i++) ext_hist.push_back(1'b1);
      e_por = 1'b1;
      e_per = 1'b1;
      e_cpu = 1'b1;
    end else begin
      s = ext_hist.pop_front();
      ext_hist.push_back(e);
      if (k > por_end && (w || !s)) begin
        base    = k;
        m_cause = !s ? 2'b11 : 2'b10;
      end
      e_por = (k < por_end);
      e_per = e_por || (k < base + STRETCH);
      e_cpu = e_por || (k < base + STRETCH + PERIPH_GAP);
    end
    check_val("power_on_reset", {1'b0, power_on_reset}, {1'b0, e_por});
    check_val("periph_reset", {1'b0, periph_reset}, {1'b0, e_per});
    check_val("cpu_reset", {1'b0, cpu_reset}, {1'b0, e_cpu});
    check_val("busy", {1'b0, busy}, {1'b0, e_cpu});
    check_val("cause", cause, m_cause);
    k++;
  endtask

  initial begin
    int burst;
    burst = 0;
    // Power-up, then a watchdog pulse in RUN.
    repeat (3) step(1'b1, 1'b0, 1'b1);
    repeat (30) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (25) step(1'b0, 1'b0, 1'b1);
    // Pin held low for 30 cycles.
    repeat (30) step(1'b0, 1'b0, 1'b0);
    repeat (30) step(1'b0, 1'b0, 1'b1);
    // Watchdog and synchronised pin low on the same edge.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (25) step(1'b0, 1'b0, 1'b1);
    // Watchdog during POR (ignored) and during PERIPH at edge 22.
    repeat (2) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (21) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (30) step(1'b0, 1'b0, 1'b1);
    // Reset asserted while in HOLD.
    step(1'b0, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    repeat (30) step(1'b0, 1'b0, 1'b1);
    // Random mix of watchdog pulses, pin bursts and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      logic r, w, e;
      if (burst > 0) begin
        e = 1'b0;
        burst--;
      end else if ($urandom % 150 == 0) begin
        burst = int'($urandom_range(40, 1));
        e     = 1'b0;
      end else begin
        e = 1'b1;
      end
      r = ($urandom % 500 == 0);
      w = ($urandom % 40 == 0);
      step(r, w, e);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
